// File: rtl/mc_core.sv
// ---------------------------------------------------------------------------
// mc_core -- small multi-cycle LEGv8-style core
//
// Purpose
//   Executes a subset of LEGv8 instructions (ADD, SUB, AND, ORR, ADDI, LDUR,
//   STUR, CBZ, B) one at a time through FETCH -> DECODE -> EXEC -> (MEM) ->
//   (WB). Any other opcode parks the core in HALT until reset.
//
// Parameters
//   XLEN      datapath/address width, 32 or 64 (default 64)
//   RESET_PC  first fetch address after reset (default 0)
//
// Ports
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   o_imem_req/o_imem_addr        instruction fetch request and address (PC)
//   i_imem_ack/i_imem_rdata       fetch accepted, instruction word valid
//   o_dmem_req/o_dmem_we          data access request, 1 = store
//   o_dmem_addr/o_dmem_wdata      data address and store data
//   i_dmem_ack/i_dmem_rdata       access complete, load data valid
//   o_retire                      one-cycle pulse per completed instruction
//   o_halt                        core stopped on an illegal opcode
//
// Build option
//   MC_CORE_PERF_EN  adds 64-bit o_cycle_cnt (non-HALT cycles) and
//                    o_instret_cnt (retired instructions) outputs.
// ---------------------------------------------------------------------------
module mc_core #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic            o_retire,
    output logic            o_halt
`ifdef MC_CORE_PERF_EN
    ,
    output logic [63:0]     o_cycle_cnt,
    output logic [63:0]     o_instret_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_ORR,
        OP_ADDI,
        OP_LDUR,
        OP_STUR,
        OP_CBZ,
        OP_B,
        OP_ILL
    } op_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_opa;
    logic [XLEN-1:0] r_opb;
    logic [XLEN-1:0] r_res;
    logic [XLEN-1:0] r_rf [32];

    op_t             w_op;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_rn_val;
    logic [XLEN-1:0] w_rb_val;
    logic [4:0]      w_rb_idx;
    logic [XLEN-1:0] w_zimm12;
    logic [XLEN-1:0] w_simm9;
    logic [XLEN-1:0] w_off19;
    logic [XLEN-1:0] w_off26;
    logic [XLEN-1:0] w_pc_plus4;
    logic            w_retire;
    logic            w_imem_req;
    logic            w_dmem_req;
    logic            w_dmem_we;

    // Opcode decode. The IR is stable from DECODE until the instruction
    // retires, so the decode stays combinational instead of being registered.
    always_comb begin
        w_op = OP_ILL;
        if (r_ir[31:21] == 11'b10001011000)      w_op = OP_ADD;
        else if (r_ir[31:21] == 11'b11001011000) w_op = OP_SUB;
        else if (r_ir[31:21] == 11'b10001010000) w_op = OP_AND;
        else if (r_ir[31:21] == 11'b10101010000) w_op = OP_ORR;
        else if (r_ir[31:22] == 10'b1001000100)  w_op = OP_ADDI;
        else if (r_ir[31:21] == 11'b11111000010) w_op = OP_LDUR;
        else if (r_ir[31:21] == 11'b11111000000) w_op = OP_STUR;
        else if (r_ir[31:24] == 8'b10110100)     w_op = OP_CBZ;
        else if (r_ir[31:26] == 6'b000101)       w_op = OP_B;
    end

    assign w_zimm12   = {{(XLEN-12){1'b0}}, r_ir[21:10]};
    assign w_simm9    = {{(XLEN-9){r_ir[20]}}, r_ir[20:12]};
    assign w_off19    = {{(XLEN-21){r_ir[23]}}, r_ir[23:5], 2'b00};
    assign w_off26    = {{(XLEN-28){r_ir[25]}}, r_ir[25:0], 2'b00};
    assign w_pc_plus4 = r_pc + XLEN'(4);

    // Second operand comes from Rm for register-register ops and from Rt for
    // STUR (store data) and CBZ (tested value). XZR always reads as zero.
    assign w_rb_idx = (w_op == OP_STUR || w_op == OP_CBZ) ? r_ir[4:0] : r_ir[20:16];
    assign w_rn_val = (r_ir[9:5] == 5'd31) ? '0 : r_rf[r_ir[9:5]];
    assign w_rb_val = (w_rb_idx == 5'd31) ? '0 : r_rf[w_rb_idx];

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = r_opa + r_opb;
            OP_SUB:  w_alu = r_opa - r_opb;
            OP_AND:  w_alu = r_opa & r_opb;
            OP_ORR:  w_alu = r_opa | r_opb;
            OP_ADDI: w_alu = r_opa + w_zimm12;
            OP_LDUR,
            OP_STUR: w_alu = r_opa + w_simm9;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_imem_req   = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (i_imem_ack) w_state_next = DECODE;
            end
            DECODE: begin
                w_state_next = (w_op == OP_ILL) ? HALT : EXEC;
            end
            EXEC: begin
                case (w_op)
                    OP_CBZ, OP_B: begin
                        w_retire     = 1'b1;
                        w_state_next = FETCH;
                    end
                    OP_LDUR, OP_STUR: w_state_next = MEM;
                    default:          w_state_next = WB;
                endcase
            end
            MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = (w_op == OP_STUR);
                if (i_dmem_ack) begin
                    if (w_op == OP_STUR) begin
                        w_retire     = 1'b1;
                        w_state_next = FETCH;
                    end else begin
                        w_state_next = WB;
                    end
                end
            end
            WB: begin
                w_retire     = 1'b1;
                w_state_next = FETCH;
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = FETCH;
        endcase
    end

    // Datapath. Branches set the PC in EXEC; every other instruction
    // advances it by 4 in the cycle it retires.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_opa <= '0;
            r_opb <= '0;
            r_res <= '0;
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (i_imem_ack) r_ir <= i_imem_rdata;
                end
                DECODE: begin
                    r_opa <= w_rn_val;
                    r_opb <= w_rb_val;
                end
                EXEC: begin
                    if (w_op == OP_CBZ) begin
                        r_pc <= (r_opb == '0) ? (r_pc + w_off19) : w_pc_plus4;
                    end else if (w_op == OP_B) begin
                        r_pc <= r_pc + w_off26;
                    end else begin
                        r_res <= w_alu;
                    end
                end
                MEM: begin
                    if (i_dmem_ack) begin
                        if (w_op == OP_STUR) r_pc  <= w_pc_plus4;
                        else                 r_res <= i_dmem_rdata;
                    end
                end
                WB: begin
                    if (r_ir[4:0] != 5'd31) r_rf[r_ir[4:0]] <= r_res;
                    r_pc <= w_pc_plus4;
                end
                default: ;
            endcase
        end
    end

    // The FSM already sits in FETCH during reset, so the fetch request is
    // masked by reset to keep all outputs quiet until release.
    assign o_imem_req   = w_imem_req & ~i_rst;
    assign o_imem_addr  = r_pc;
    assign o_dmem_req   = w_dmem_req;
    assign o_dmem_we    = w_dmem_we;
    assign o_dmem_addr  = r_res;
    assign o_dmem_wdata = r_opb;
    assign o_retire     = w_retire;
    assign o_halt       = (r_state == HALT);

`ifdef MC_CORE_PERF_EN
    logic [63:0] r_cycle_cnt;
    logic [63:0] r_instret_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != HALT) r_cycle_cnt   <= r_cycle_cnt + 64'd1;
            if (w_retire)        r_instret_cnt <= r_instret_cnt + 64'd1;
        end
    end

    assign o_cycle_cnt   = r_cycle_cnt;
    assign o_instret_cnt = r_instret_cnt;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
